riscv_fetch_unit: RTL and testbench

// - Instruction fetch front end; produces the 32-bit instruction word consumed by the decoder.
// - Issues in-order word reads to instruction memory and buffers responses in a FIFO.
// - Presents {inst, pc} to decode with a valid/ready handshake.
// - Redirects (jump/branch target, PC_ALU / PC_B_TARGET) flush the buffer and discard stale in-flight responses.

---
 rtl/riscv_fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_riscv_fetch_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : riscv_fetch_unit                                             |
// | Description : Instruction fetch front end. Issues in-order word reads to   |
// |               instruction memory, tracks each request's PC in a small      |
// |               queue, buffers responses in a FIFO and presents {inst, pc}   |
// |               to decode with a valid/ready handshake. A redirect flushes   |
// |               the buffer and drops responses to requests already in flight.|
// | Options     : define RISCV_FETCH_ALIGN_CHECK_EN to add fetch_misalign_o    |
// |               and a fault state entered on a misaligned redirect.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
  output logic        fetch_misalign_o,
`endif
  input  logic        inst_ready_i
);

  localparam int unsigned c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned c_CW = c_AW + 1;
  localparam logic [c_CW+1:0] c_DEPTH = (c_CW + 2)'(FIFO_DEPTH);
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
  localparam logic c_ALIGN_CHECK = 1'b1;
`else
  localparam logic c_ALIGN_CHECK = 1'b0;
`endif

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_FAULT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_fetch_pc;
  logic [c_CW-1:0]   r_outst;
  logic [c_CW-1:0]   r_kill;
  logic [c_CW-1:0]   r_count;
  logic [c_AW-1:0]   r_wptr;
  logic [c_AW-1:0]   r_rptr;
  logic [c_AW-1:0]   r_pq_wptr;
  logic [c_AW-1:0]   r_pq_rptr;
  logic [31:0]       r_pq        [FIFO_DEPTH];
  logic [31:0]       r_fifo_inst [FIFO_DEPTH];
  logic [31:0]       r_fifo_pc   [FIFO_DEPTH];

  logic              w_issue;
  logic              w_live;
  logic              w_push;
  logic              w_pop;
  logic              w_misaligned;
  logic [c_CW+1:0]   w_credit;

  // Every slot already promised (in flight, being killed, or buffered) counts
  // against the FIFO, so a response can never find the buffer full.
  assign w_credit     = {2'b00, r_outst} + {2'b00, r_kill} + {2'b00, r_count};
  assign w_issue      = imem_req_o & imem_gnt_i;
  assign w_live       = imem_rvalid_i & (r_kill == '0);
  assign w_push       = w_live & ~redirect_i;
  assign w_pop        = inst_valid_o & inst_ready_i;
  assign w_misaligned = c_ALIGN_CHECK & (redirect_pc_i[1:0] != 2'b00);

  assign imem_addr_o  = r_fetch_pc;
  assign inst_valid_o = (r_count != '0);
  assign inst_o       = inst_valid_o ? r_fifo_inst[r_rptr] : 32'h0;
  assign inst_pc_o    = inst_valid_o ? r_fifo_pc[r_rptr]   : 32'h0;
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
  assign fetch_misalign_o = (r_state == S_FAULT);
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  // Next state and request generation; a fault only clears on an aligned redirect.
  always_comb begin
    w_state_nxt = r_state;
    imem_req_o  = 1'b0;
    case (r_state)
      S_RUN: begin
        imem_req_o = fetch_en_i & ~redirect_i & (w_credit < c_DEPTH);
        if (redirect_i && w_misaligned) w_state_nxt = S_FAULT;
      end
      S_FAULT: begin
        if (redirect_i && !w_misaligned) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Fetch address: redirect target (word aligned) or advance on each grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_fetch_pc <= RESET_PC;
    else if (redirect_i) r_fetch_pc <= {redirect_pc_i[31:2], 2'b00};
    else if (w_issue)    r_fetch_pc <= r_fetch_pc + 32'd4;
  end

  // In-flight and kill counters; on redirect every live outstanding read that
  // does not return this very cycle becomes a read to drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outst <= '0;
      r_kill  <= '0;
    end else if (redirect_i) begin
      r_outst <= '0;
      r_kill  <= r_kill + r_outst - c_CW'(imem_rvalid_i);
    end else begin
      r_outst <= r_outst + c_CW'(w_issue) - c_CW'(w_live);
      if (imem_rvalid_i && (r_kill != '0)) r_kill <= r_kill - c_CW'(1);
    end
  end

  // Per-request PC queue pointers; flushed with the outstanding count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pq_wptr <= '0;
      r_pq_rptr <= '0;
    end else if (redirect_i) begin
      r_pq_wptr <= '0;
      r_pq_rptr <= '0;
    end else begin
      if (w_issue) r_pq_wptr <= r_pq_wptr + c_AW'(1);
      if (w_live)  r_pq_rptr <= r_pq_rptr + c_AW'(1);
    end
  end

  // PC queue storage, written with the address of each granted request.
  always_ff @(posedge clk) begin
    if (w_issue) r_pq[r_pq_wptr] <= r_fetch_pc;
  end

  // Instruction FIFO pointers and occupancy; redirect empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (redirect_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_AW'(1);
      if (w_pop)  r_rptr <= r_rptr + c_AW'(1);
      r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
    end
  end

  // Instruction FIFO storage: response data paired with its request PC.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_inst[r_wptr] <= imem_rdata_i;
      r_fifo_pc[r_wptr]   <= r_pq[r_pq_rptr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_riscv_fetch_unit                                          |
// | Description : Directed bench for riscv_fetch_unit with an in-order         |
// |               instruction memory model of configurable latency.            |
// | Options     : define RISCV_FETCH_ALIGN_CHECK_EN to cover the fault path.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_riscv_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  riscv_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en_i    (fetch_en),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .inst_valid_o  (inst_valid),
    .inst_o        (inst),
    .inst_pc_o     (inst_pc),
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
    .fetch_misalign_o (fetch_misalign),
`endif
    .inst_ready_i  (inst_ready)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  int          cyc;
  int          lat;
  int          n_cmp;
  int          n_fail;

  logic        obs_req;
  logic        obs_acc;
  logic [31:0] obs_addr;
  logic        obs_valid;
  logic [31:0] obs_inst;
  logic [31:0] obs_pc;
  logic        obs_mis;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // One clock cycle: drive memory response, sample before the edge, advance.
  task automatic step();
    logic [31:0] acc_addr;
    imem_gnt = 1'b1;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_data(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0BAD_0BAD;
    end
    #1;
    obs_req   = imem_req;
    obs_acc   = imem_req & imem_gnt;
    obs_addr  = imem_addr;
    obs_valid = inst_valid;
    obs_inst  = inst;
    obs_pc    = inst_pc;
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
    obs_mis   = fetch_misalign;
`else
    obs_mis   = 1'b0;
`endif
    acc_addr  = imem_addr;
    @(posedge clk);
    @(negedge clk);
    if (obs_acc) pend_q.push_back('{addr: acc_addr, due: cyc + lat});
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
    pend_q.delete();
    cyc = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
    pend_q.delete();
    cyc = 0;
    @(negedge clk);
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
    n_cmp++; if (inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h expected 00000000", inst); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 00000000", inst_pc); end
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
    n_cmp++; if (fetch_misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", fetch_misalign); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    fetch_en = 1'b1; inst_ready = 1'b1; lat = 1;
    for (int n = 0; n < 10; n++) begin
      step();
      n_cmp++; if (obs_req !== 1'b1) begin n_fail++; $display("FAIL stream_req[%0d]: got %b expected 1", n, obs_req); end
      n_cmp++; if (obs_addr !== 32'(4 * n)) begin n_fail++; $display("FAIL stream_addr[%0d]: got %h expected %h", n, obs_addr, 32'(4 * n)); end
      if (n >= 2) begin
        n_cmp++; if (obs_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b expected 1", n, obs_valid); end
        n_cmp++; if (obs_pc !== 32'(4 * (n - 2))) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h expected %h", n, obs_pc, 32'(4 * (n - 2))); end
        n_cmp++; if (obs_inst !== mem_data(32'(4 * (n - 2)))) begin n_fail++; $display("FAIL stream_inst[%0d]: got %h expected %h", n, obs_inst, mem_data(32'(4 * (n - 2)))); end
      end
    end
    // Asynchronous reset mid-cycle must clear state without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %b expected 0", inst_valid); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL async_rst_addr: got %h expected 00000000", imem_addr); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_backpressure();
    int gnts;
    do_reset();
    fetch_en = 1'b1; inst_ready = 1'b0; lat = 1;
    gnts = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (obs_acc) gnts++;
      if (n >= 2) begin
        n_cmp++; if (obs_valid !== 1'b1 || obs_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head[%0d]: got valid=%b pc=%h expected valid=1 pc=00000000", n, obs_valid, obs_pc); end
      end
    end
    n_cmp++; if (gnts !== 4) begin n_fail++; $display("FAIL bp_gnts: got %0d expected 4", gnts); end
    n_cmp++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_off: got %b expected 0", obs_req); end
    inst_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++; if (obs_valid !== 1'b1 || obs_pc !== 32'(4 * k)) begin n_fail++; $display("FAIL bp_drain[%0d]: got valid=%b pc=%h expected valid=1 pc=%h", k, obs_valid, obs_pc, 32'(4 * k)); end
    end
  endtask

  task automatic test_fetch_en();
    do_reset();
    fetch_en = 1'b1; inst_ready = 1'b1; lat = 1;
    repeat (3) step();
    fetch_en = 1'b0;
    step();
    n_cmp++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL fen_req0: got %b expected 0", obs_req); end
    n_cmp++; if (obs_valid !== 1'b1 || obs_pc !== 32'h4) begin n_fail++; $display("FAIL fen_head0: got valid=%b pc=%h expected valid=1 pc=00000004", obs_valid, obs_pc); end
    step();
    n_cmp++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL fen_req1: got %b expected 0", obs_req); end
    n_cmp++; if (obs_valid !== 1'b1 || obs_pc !== 32'h8) begin n_fail++; $display("FAIL fen_inflight: got valid=%b pc=%h expected valid=1 pc=00000008", obs_valid, obs_pc); end
    step();
    n_cmp++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL fen_empty: got %b expected 0", obs_valid); end
  endtask

  task automatic test_redirect_stale();
    int idx;
    do_reset();
    fetch_en = 1'b1; inst_ready = 1'b1; lat = 5;
    repeat (3) step();
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    n_cmp++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL stale_redir_req: got %b expected 0", obs_req); end
    idx = 0;
    for (int k = 0; k < 30 && idx < 3; k++) begin
      step();
      if (k == 0) begin
        n_cmp++; if (obs_req !== 1'b1 || obs_addr !== 32'h100) begin n_fail++; $display("FAIL stale_first_req: got req=%b addr=%h expected req=1 addr=00000100", obs_req, obs_addr); end
      end
      if (obs_valid) begin
        n_cmp++; if (obs_pc !== 32'h100 + 32'(4 * idx) || obs_inst !== mem_data(32'h100 + 32'(4 * idx))) begin
          n_fail++; $display("FAIL stale_seq[%0d]: got pc=%h inst=%h expected pc=%h", idx, obs_pc, obs_inst, 32'h100 + 32'(4 * idx));
        end
        idx++;
      end
    end
    n_cmp++; if (idx !== 3) begin n_fail++; $display("FAIL stale_timeout: got %0d entries expected 3", idx); end
  endtask

  task automatic test_redirect_collision();
    do_reset();
    fetch_en = 1'b1; inst_ready = 1'b1; lat = 1;
    repeat (3) step();
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    n_cmp++; if (obs_valid !== 1'b1 || obs_pc !== 32'h4) begin n_fail++; $display("FAIL coll_pop: got valid=%b pc=%h expected valid=1 pc=00000004", obs_valid, obs_pc); end
    n_cmp++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL coll_req: got %b expected 0", obs_req); end
    step();
    n_cmp++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL coll_flush: got %b expected 0", obs_valid); end
    n_cmp++; if (obs_req !== 1'b1 || obs_addr !== 32'h40) begin n_fail++; $display("FAIL coll_new_req: got req=%b addr=%h expected req=1 addr=00000040", obs_req, obs_addr); end
    step();
    n_cmp++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL coll_gap: got %b expected 0", obs_valid); end
    step();
    n_cmp++; if (obs_valid !== 1'b1 || obs_pc !== 32'h40) begin n_fail++; $display("FAIL coll_new_head: got valid=%b pc=%h expected valid=1 pc=00000040", obs_valid, obs_pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    fetch_en = 1'b1; inst_ready = 1'b1; lat = 1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    step();
    n_cmp++; if (obs_req !== 1'b1 || obs_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top: got req=%b addr=%h expected req=1 addr=fffffffc", obs_req, obs_addr); end
    step();
    n_cmp++; if (obs_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_zero: got %h expected 00000000", obs_addr); end
    step();
    n_cmp++; if (obs_valid !== 1'b1 || obs_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_head0: got valid=%b pc=%h expected valid=1 pc=fffffffc", obs_valid, obs_pc); end
    step();
    n_cmp++; if (obs_valid !== 1'b1 || obs_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_head1: got valid=%b pc=%h expected valid=1 pc=00000000", obs_valid, obs_pc); end
  endtask

  task automatic test_back_to_back();
    logic found;
    do_reset();
    fetch_en = 1'b1; inst_ready = 1'b1; lat = 2;
    repeat (2) step();
    redirect = 1'b1; redirect_pc = 32'h300;
    step();
    n_cmp++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL b2b_req0: got %b expected 0", obs_req); end
    redirect_pc = 32'h400;
    step();
    redirect = 1'b0;
    n_cmp++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL b2b_req1: got %b expected 0", obs_req); end
    step();
    n_cmp++; if (obs_req !== 1'b1 || obs_addr !== 32'h400) begin n_fail++; $display("FAIL b2b_addr: got req=%b addr=%h expected req=1 addr=00000400", obs_req, obs_addr); end
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (obs_valid) begin
        found = 1'b1;
        n_cmp++; if (obs_pc !== 32'h400) begin n_fail++; $display("FAIL b2b_head: got %h expected 00000400", obs_pc); end
      end
    end
    n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL b2b_timeout: got no instruction expected pc 00000400"); end
  endtask

  task automatic test_align();
    do_reset();
    fetch_en = 1'b1; inst_ready = 1'b1; lat = 1;
    redirect = 1'b1; redirect_pc = 32'h102;
    step();
    redirect = 1'b0;
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (obs_mis !== 1'b1 || obs_req !== 1'b0) begin n_fail++; $display("FAIL align_fault[%0d]: got mis=%b req=%b expected mis=1 req=0", k, obs_mis, obs_req); end
    end
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    step();
    n_cmp++; if (obs_mis !== 1'b0) begin n_fail++; $display("FAIL align_clear: got %b expected 0", obs_mis); end
    n_cmp++; if (obs_req !== 1'b1 || obs_addr !== 32'h200) begin n_fail++; $display("FAIL align_resume: got req=%b addr=%h expected req=1 addr=00000200", obs_req, obs_addr); end
`else
    step();
    n_cmp++; if (obs_req !== 1'b1 || obs_addr !== 32'h100) begin n_fail++; $display("FAIL align_ignored: got req=%b addr=%h expected req=1 addr=00000100", obs_req, obs_addr); end
`endif
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    lat    = 1;
    test_reset();
    test_stream();
    test_backpressure();
    test_fetch_en();
    test_redirect_stale();
    test_redirect_collision();
    test_wrap();
    test_back_to_back();
    test_align();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
